// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, serviced from word RAM
// or the LED/RGB MMIO window after WAIT_STATES cycles, answered with data or an error flag.
module data_mem_responder #(
   parameter int          MEM_WORDS   = 2048,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        led,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [3:0]  WS        = 4'(WAIT_STATES);
   localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        wr_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [MEM_WORDS];

   logic        cur_write;
   logic [2:0]  cur_f3;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        commit;
   logic        bad_f3;
   logic        misal;
   logic        in_ram;
   logic        mmio_hit;
   logic        acc_err;
   logic [AW-1:0] ram_idx;
   logic [31:0] ram_word;
   logic [31:0] mmio_word;
   logic [31:0] load_data;
   logic [3:0]  st_be;
   logic [31:0] st_data;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
      logic [31:0] sh8;
      logic [31:0] sh16;
      sh8  = word >> {lane, 3'b000};
      sh16 = word >> {lane[1], 4'b0000};
      case (f3[1:0])
         2'b00:   load_extend = f3[2] ? {24'd0, sh8[7:0]}   : {{24{sh8[7]}}, sh8[7:0]};
         2'b01:   load_extend = f3[2] ? {16'd0, sh16[15:0]} : {{16{sh16[15]}}, sh16[15:0]};
         default: load_extend = word;
      endcase
   endfunction

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);

   // With zero wait states the access commits on the accept edge, straight from the request bus.
   always_comb begin
      cur_write = (state == S_IDLE) ? req_write  : wr_q;
      cur_f3    = (state == S_IDLE) ? req_funct3 : f3_q;
      cur_addr  = (state == S_IDLE) ? req_addr   : addr_q;
      cur_wdata = (state == S_IDLE) ? req_wdata  : wdata_q;
      commit    = reset_n && (((state == S_IDLE) && req_valid && (WS == 4'd0)) ||
                              ((state == S_BUSY) && (wait_cnt == 4'd1)));
   end

   always_comb begin
      if (cur_write)
         bad_f3 = cur_f3[2] || (cur_f3[1:0] == 2'b11);
      else
         bad_f3 = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111);
      misal    = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                 ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
      in_ram   = ({1'b0, cur_addr} < RAM_BYTES);
      mmio_hit = !in_ram && (cur_addr[31:4] == MMIO_BASE[31:4]);
      acc_err  = bad_f3 || misal || !(in_ram || mmio_hit) ||
                 (mmio_hit && (cur_f3 != 3'b010));
   end

   always_comb begin
      ram_idx  = cur_addr[AW+1:2];
      ram_word = mem[ram_idx];
      case (cur_addr[3:2])
         2'd0:    mmio_word = {31'd0, led};
         2'd1:    mmio_word = {24'd0, red};
         2'd2:    mmio_word = {24'd0, green};
         default: mmio_word = {24'd0, blue};
      endcase
      load_data = mmio_hit ? mmio_word : load_extend(ram_word, cur_addr[1:0], cur_f3);
   end

   always_comb begin
      case (cur_f3[1:0])
         2'b00: begin
            st_be   = 4'b0001 << cur_addr[1:0];
            st_data = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{cur_wdata[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = cur_wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (commit && cur_write && !acc_err && in_ram) begin
         for (int i = 0; i < 4; i++)
            if (st_be[i])
               mem[ram_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if ((state == S_IDLE) && req_valid) begin
         wr_q    <= req_write;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_error <= 1'b0;
         led       <= 1'b0;
         red       <= 8'd0;
         green     <= 8'd0;
         blue      <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  wait_cnt <= WS;
                  state    <= (WS == 4'd0) ? S_RESP : S_BUSY;
               end
            end
            S_BUSY: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1)
                  state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (commit) begin
            rsp_error <= acc_err;
            rsp_rdata <= (acc_err || cur_write) ? 32'd0 : load_data;
            if (cur_write && !acc_err && mmio_hit) begin
               case (cur_addr[3:2])
                  2'd0:    led   <= cur_wdata[0];
                  2'd1:    red   <= cur_wdata[7:0];
                  2'd2:    green <= cur_wdata[7:0];
                  default: blue  <= cur_wdata[7:0];
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (WAIT_STATES=3): RAM lanes, errors, stalls, MMIO, reset in BUSY.
module tb_data_mem_responder;

   localparam int          WS   = 3;
   localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        led;
   logic [7:0]  red, green, blue;

   int          n_total = 0;
   int          n_bad = 0;
   logic [31:0] got_rd;
   logic        got_err;
   int          got_lat;

   data_mem_responder #(.MEM_WORDS(2048), .WAIT_STATES(WS), .MMIO_BASE(MMIO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .led(led), .red(red), .green(green), .blue(blue)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   // One full transaction; latency counts edges from the accept edge to the first rsp_valid sample.
   task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
      bit ok;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      got_lat = 0;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         got_lat++;
         @(negedge clk);
         if (rsp_valid) begin ok = 1; break; end
      end
      if (!ok) check("rsp_timeout", 32'd0, 32'd1);
      got_rd  = rsp_rdata;
      got_err = rsp_error;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_error", {31'd0, rsp_error}, 32'd0);
      check("rst_leds", {7'd0, led, red, green, blue}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_ready", {31'd0, req_ready}, 32'd1);

      xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      check("sw_err", {31'd0, got_err}, 32'd0);
      check("sw_rdata", got_rd, 32'd0);
      check("sw_lat", got_lat, WS + 1);
      xact(1'b0, 3'b010, 32'h10, 32'd0);
      check("lw_data", got_rd, 32'hDEADBEEF);
      check("lw_err", {31'd0, got_err}, 32'd0);
      check("lw_lat", got_lat, WS + 1);

      xact(1'b1, 3'b000, 32'h13, 32'h0000_0080);
      check("sb_err", {31'd0, got_err}, 32'd0);
      xact(1'b0, 3'b000, 32'h13, 32'd0);
      check("lb_data", got_rd, 32'hFFFF_FF80);
      xact(1'b0, 3'b100, 32'h13, 32'd0);
      check("lbu_data", got_rd, 32'h0000_0080);
      xact(1'b0, 3'b010, 32'h10, 32'd0);
      check("lw_merged", got_rd, 32'h80AD_BEEF);
      xact(1'b0, 3'b001, 32'h12, 32'd0);
      check("lh_hi", got_rd, 32'hFFFF_80AD);
      xact(1'b0, 3'b101, 32'h10, 32'd0);
      check("lhu_lo", got_rd, 32'h0000_BEEF);

      xact(1'b0, 3'b001, 32'h11, 32'd0);
      check("lh_misal_err", {31'd0, got_err}, 32'd1);
      check("lh_misal_rd", got_rd, 32'd0);
      xact(1'b1, 3'b010, 32'h12, 32'd0);
      check("sw_misal_err", {31'd0, got_err}, 32'd1);
      xact(1'b0, 3'b011, 32'h10, 32'd0);
      check("bad_f3_err", {31'd0, got_err}, 32'd1);
      xact(1'b0, 3'b010, 32'h2000, 32'd0);
      check("unmapped_err", {31'd0, got_err}, 32'd1);
      xact(1'b1, 3'b001, 32'h12, 32'h0000_1234);
      check("sh_err", {31'd0, got_err}, 32'd0);
      xact(1'b0, 3'b010, 32'h10, 32'd0);
      check("lw_after_sh", got_rd, 32'h1234_BEEF);

      // Backpressure: response held while a second request waits unaccepted.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      #1 req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h1111_1111;
      for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, rsp_valid}, 32'd1);
         check("stall_rdata", rsp_rdata, 32'h1234_BEEF);
         check("stall_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      xact(1'b0, 3'b010, 32'h10, 32'd0);
      check("no_second_accept", got_rd, 32'h1234_BEEF);

      xact(1'b1, 3'b010, MMIO, 32'h1);
      check("led_set", {31'd0, led}, 32'd1);
      xact(1'b1, 3'b010, MMIO + 32'h4, 32'hA5);
      check("red_set", {24'd0, red}, 32'hA5);
      xact(1'b1, 3'b010, MMIO + 32'h8, 32'h1233C);
      check("green_set", {24'd0, green}, 32'h3C);
      xact(1'b0, 3'b010, MMIO + 32'h4, 32'd0);
      check("lw_red", got_rd, 32'h0000_00A5);
      xact(1'b1, 3'b000, MMIO, 32'h0);
      check("mmio_sb_err", {31'd0, got_err}, 32'd1);
      check("led_kept", {31'd0, led}, 32'd1);

      xact(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("rb_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rb_outputs", {7'd0, led, red, green, blue}, 32'd0);
      check("rb_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      xact(1'b0, 3'b010, 32'h20, 32'd0);
      check("rb_no_write", got_rd, 32'hCAFE_F00D);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck want finish");
      $fatal(1);
   end

endmodule
